// File: rtl/debounce_sync_pkg.sv
// rtl/debounce_sync_pkg.sv - shared constants for input debounce/synchronizer blocks
package debounce_sync_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  localparam int GLITCH_CNT_W = 8;

  // Board-level default stability window, in clk cycles
  localparam int DB_CYCLES_DEFAULT = 1000;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (v == {GLITCH_CNT_W{1'b1}}) ? v : v + GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for a single asynchronous bit
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw input through the chain; only the last flop is consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer + stability-counter debouncer; DEBOUNCE_GLITCH_CNT_EN enables glitch counting
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int             CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (s)
  );

  // Debounce FSM: a differing synchronized level must hold DB_CYCLES samples to be accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s != dout) begin
            state <= ST_COUNT;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (s == dout) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dout  <= s;
            rise  <= s;
            fall  <= ~s;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_COUNT);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    glitch_evt;
  logic [GLITCH_CNT_W-1:0] glitch_q;

  // A pending candidate that falls back to the current level is a glitch
  assign glitch_evt = (state == ST_COUNT) && (s == dout);

  // Saturating count of aborted transitions, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (glitch_evt) begin
      glitch_q <= sat_inc(glitch_q);
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that turns a raw, asynchronous, bouncy 1-bit signal (push-button, switch, external strobe) into a clean, clock-synchronous level plus single-cycle edge pulses. It sits directly upstream of the register stages in the design, such as the d_ff data input. It sits after the board pin and in front of any logic clocked by `clk`. Synchronization uses a multi-flop chain, and debouncing uses a stability counter driven by a two-state FSM.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count; legal range ≥ 2.
- `DB_CYCLES`, 1000: consecutive stable cycles required to accept a new level; legal range ≥ 2.
- `CNT_W`, `$clog2(DB_CYCLES)`: stability counter width (derived, not overridden).

- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `din`, in, 1: raw asynchronous input.
- `dout`, out, 1: debounced, synchronized level.
- `rise`, out, 1: one-cycle pulse when `dout` goes 0→1.
- `fall`, out, 1: one-cycle pulse when `dout` goes 1→0.
- `busy`, out, 1: high while the FSM is in COUNT.
- `glitch_cnt`, out, 8: aborted-transition count (see Configuration).

## Operation
- The synchronizer shifts `din` through `SYNC_STAGES` flops. The last stage is `s`. No logic reads earlier stages.
- FSM states:
  - IDLE: `s == dout`.
  - COUNT: candidate new level pending.
- FSM transitions:
  - IDLE, `s != dout` → COUNT, `cnt <= 1`.
  - IDLE, `s == dout` → stay.
  - COUNT, `s == dout` (bounce back) → IDLE, `cnt <= 0`, glitch event.
  - COUNT, `s != dout`, `cnt == DB_CYCLES-1` → IDLE, `dout <= s`, `cnt <= 0`, pulse `rise` or `fall`.
  - COUNT, `s != dout`, otherwise → `cnt <= cnt+1`.
- `busy` = (state == COUNT).
- `rise` and `fall` are mutually exclusive and are never high for two consecutive cycles.
- `cnt` never exceeds `DB_CYCLES-1`, so no wrap-around is possible.

## Timing
- All outputs are registered.
- Reset values: `dout`=0, `rise`=0, `fall`=0, `busy`=0, `glitch_cnt`=0. Synchronizer flops=0, state=IDLE, `cnt`=0.
- Reset acts only on a rising `clk` with `rst_n` low and overrides all other updates. Asserting reset mid-COUNT discards the pending transition with no pulse and no glitch count.
- Latency: let edge 1 be the first edge at which stage 0 captures a new `din` level that then stays stable. `dout` and the edge pulse update at edge `SYNC_STAGES + DB_CYCLES`.
- A `din` level that is stable through fewer than `DB_CYCLES` consecutive samples of `s` never reaches `dout`.
- After reset is released with `din` held 1, `dout` rises after the normal latency and `rise` pulses once.
- A `din` change that arrives during the final COUNT cycle is not visible to the FSM until `SYNC_STAGES` edges later. The in-flight acceptance completes normally.

## Configuration
- `DEBOUNCE_GLITCH_CNT_EN` defined:
  - `glitch_cnt` increments by 1 on each COUNT→IDLE bounce-back.
  - It saturates at 255 and clears only on reset.
- `DEBOUNCE_GLITCH_CNT_EN` undefined:
  - The counter logic is not built.
  - The `glitch_cnt` port remains and is tied to 8'd0.

## Structure
- Shared package/include holds:
  - FSM state encodings `ST_IDLE=1'b0` and `ST_COUNT=1'b1`.
  - `GLITCH_CNT_W=8`.
  - The default `DB_CYCLES` used across the board-level designs.
- Sub-module `sync_chain` is parameterized by `STAGES`, with ports `clk`, `rst_n`, `d`, `q`. Other input-capture blocks reuse it.
- Debounce FSM, counter, and pulse generation live in `debounce_sync` itself.

## Test plan
Bench config: `SYNC_STAGES=2`, `DB_CYCLES=4`, macro defined.
- Clean rise: reset, then `din` 0→1 held 20 cycles → `dout`=1 at edge 6 after the capture edge; `rise` high exactly that cycle; `busy` high edges 3–5.
- Glitch: `din`=1 for 3 cycles, then 0 → `dout` stays 0, no pulses, `glitch_cnt`=1, `busy` returns low.
- Clean fall: from `dout`=1, `din`→0 held → `dout`=0 at edge 6; `fall` high one cycle; `rise` stays low.
- Bounce train: `din` toggles every cycle for 10 cycles, then holds 1 → exactly one `rise`, 6 edges after the final stable capture.
- Reset mid-COUNT: pull `rst_n` low while `busy`=1 → next edge has all outputs 0 and no pulse; recovery matches the clean-rise scenario.
- Saturation: 300 glitches → `glitch_cnt`=255. Rebuild without the macro → `glitch_cnt`=0 throughout, and all other outputs are identical.
